// File: rtl/axi_traffic_gen_pkg.sv
// Bus widths and AXI channel payload structs for the traffic generator.
package axi_traffic_gen_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              rready;
  } axi_mosi_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
  } axi_miso_t;

endpackage

// File: rtl/axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator: writes one INCR burst of a known
// pattern, reads it back, and counts ID / data / RLAST discrepancies.
module axi_traffic_gen
  import axi_traffic_gen_pkg::*;
#(
  parameter logic [ID_W-1:0]   AXI_ID    = 4'h0,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 16'hFFFC
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output axi_mosi_t         m_axi_o,
  input  axi_miso_t         m_axi_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_cnt_o
);

  localparam int unsigned ERR_W = 16;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               done_q, busy_q;
  axi_mosi_t          mosi_q, mosi_d;

  logic [1:0]         err_inc;
  logic [ERR_W:0]     err_sum;
  logic [DATA_W-1:0]  exp_word;
  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic               unused_resp;

  assign unused_resp = ^{m_axi_i.bresp, m_axi_i.rresp};

  assign aw_hs = mosi_q.awvalid & m_axi_i.awready;
  assign w_hs  = mosi_q.wvalid  & m_axi_i.wready;
  assign b_hs  = mosi_q.bready  & m_axi_i.bvalid;
  assign ar_hs = mosi_q.arvalid & m_axi_i.arready;
  assign r_hs  = mosi_q.rready  & m_axi_i.rvalid;

  // Same pattern for write and read-back; read index free-runs past LEN.
  assign exp_word = {addr_q, 8'h5A, beat_q};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    pass_d  = pass_q;
    err_inc = 2'd0;
    err_sum = '0;
    mosi_d  = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = AW;
          addr_d  = addr_i & ADDR_MASK;
          len_d   = len_i;
          beat_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      AW: if (aw_hs) state_d = W;
      W: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (mosi_q.wlast) state_d = B;
        end
      end
      B: begin
        if (b_hs) begin
          err_inc = 2'(m_axi_i.bid != AXI_ID);
          state_d = AR;
        end
      end
      AR: begin
        if (ar_hs) begin
          state_d = R;
          beat_d  = '0;
        end
      end
      R: begin
        if (r_hs) begin
          err_inc = 2'(m_axi_i.rid != AXI_ID)
                  + 2'(m_axi_i.rdata != exp_word)
                  + 2'(m_axi_i.rlast != (beat_q == len_q));
          beat_d  = beat_q + 8'd1;
          if (m_axi_i.rlast) state_d = DONE;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Saturating error accumulation.
    err_sum = {1'b0, err_d} + 17'(err_inc);
    err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    mosi_d.awid    = AXI_ID;
    mosi_d.awaddr  = addr_d;
    mosi_d.awlen   = len_d;
    mosi_d.awsize  = 3'b010;
    mosi_d.awburst = 2'b01;
    mosi_d.awvalid = (state_d == AW);
    mosi_d.wdata   = {addr_d, 8'h5A, beat_d};
    mosi_d.wstrb   = 4'hF;
    mosi_d.wlast   = (beat_d == len_d);
    mosi_d.wvalid  = (state_d == W);
    mosi_d.bready  = (state_d == B);
    mosi_d.arid    = AXI_ID;
    mosi_d.araddr  = addr_d;
    mosi_d.arlen   = len_d;
    mosi_d.arsize  = 3'b010;
    mosi_d.arburst = 2'b01;
    mosi_d.arvalid = (state_d == AR);
    mosi_d.rready  = (state_d == R);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mosi_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
      mosi_q  <= mosi_d;
    end
  end

  assign m_axi_o   = mosi_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;

endmodule
